// File: rtl/ssd_pkg.sv
// Shared definitions for the four-digit seven-segment scan driver.
package ssd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;

  typedef logic [1:0] digit_idx_t;

  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF  = 4'b1111;
  localparam logic [SEG_W-1:0]      SEG_ALL_OFF = 7'b1111111;

  // Active-low anode pattern that enables exactly one digit.
  function automatic logic [NUM_DIGITS-1:0] anode_drive(input digit_idx_t idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/ssd_prescaler.sv
// Free-running slot timer: counts 0..DIV-1 and flags the terminal count.
module ssd_prescaler #(
  parameter int DIV   = 50000,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign tick  = (count_q == CNT_W'(DIV - 1));
  assign count = count_q;

  // Advance the count, wrapping to zero after the terminal value.
  always_comb begin
    count_d = tick ? '0 : count_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed four-digit seven-segment driver with frame-synchronous image
// updates and a short blanking gap at the start of each digit slot.
// Optional feature macro: SSD_DIM_EN adds a 2-bit brightness input that
// shortens the lit part of every slot.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_DIGITS*SEG_W-1:0] ssd,
  input  logic                        load,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
`ifdef SSD_DIM_EN
  input  logic [1:0]                  brightness,
`endif
  output logic [NUM_DIGITS-1:0]       an,
  output logic [SEG_W-1:0]            seg,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IMG_W = NUM_DIGITS * SEG_W;
  localparam logic [31:0] BLANK_END = 32'(BLANK_CYC);

  logic [CNT_W-1:0] count;
  logic             tick;
  logic [31:0]      count_ext;
  logic             frame_wrap;
  logic             in_window;
  logic [SEG_W-1:0] digit_seg;

  digit_idx_t      index_q,   index_d;
  logic [IMG_W-1:0] holding_q, holding_d;
  logic [IMG_W-1:0] display_q, display_d;
  logic            busy_q,    busy_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;

  ssd_prescaler #(
    .DIV   (SCAN_DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .tick  (tick)
  );

  assign count_ext  = 32'(count);
  assign frame_wrap = tick && (index_q == digit_idx_t'(NUM_DIGITS - 1));
  assign digit_seg  = display_q[index_q*SEG_W +: SEG_W];

`ifdef SSD_DIM_EN
  localparam int          ON_SPAN    = SCAN_DIV - BLANK_CYC;
  localparam logic [31:0] DIM_END_0  = 32'(BLANK_CYC + (ON_SPAN * 1) / 4);
  localparam logic [31:0] DIM_END_1  = 32'(BLANK_CYC + (ON_SPAN * 2) / 4);
  localparam logic [31:0] DIM_END_2  = 32'(BLANK_CYC + (ON_SPAN * 3) / 4);
  localparam logic [31:0] DIM_END_3  = 32'(BLANK_CYC + (ON_SPAN * 4) / 4);

  logic [31:0] dim_end;

  // Pick where the lit part of the slot ends for the requested brightness.
  always_comb begin
    case (brightness)
      2'd0:    dim_end = DIM_END_0;
      2'd1:    dim_end = DIM_END_1;
      2'd2:    dim_end = DIM_END_2;
      default: dim_end = DIM_END_3;
    endcase
  end

  assign in_window = (count_ext >= BLANK_END) && (count_ext < dim_end);
`else
  assign in_window = (count_ext >= BLANK_END);
`endif

  // Digit sequencing, double-buffered image hand-off and pending flag.
  always_comb begin
    index_d   = tick ? index_q + 2'd1 : index_q;
    display_d = (frame_wrap && busy_q) ? holding_q : display_q;
    holding_d = load ? ssd : holding_q;
    busy_d    = load | (busy_q & ~frame_wrap);
  end

  // Decide which anode and segment pattern the next cycle should show.
  always_comb begin
    an_d  = AN_ALL_OFF;
    seg_d = SEG_ALL_OFF;
    if (in_window && !blank_mask[index_q]) begin
      an_d  = anode_drive(index_q);
      seg_d = ~digit_seg;
    end
  end

  // State and registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q   <= '0;
      holding_q <= '0;
      display_q <= '0;
      busy_q    <= 1'b0;
      an_q      <= AN_ALL_OFF;
      seg_q     <= SEG_ALL_OFF;
    end else begin
      index_q   <= index_d;
      holding_q <= holding_d;
      display_q <= display_d;
      busy_q    <= busy_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign busy       = busy_q;
  assign frame_done = frame_wrap;

endmodule

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter BLANK_CYC, default 2: cycles at the start of each slot with all anodes off (anti-ghosting); must be less than SCAN_DIV.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ssd  input  28  segment image; [6:0] digit0 (rightmost) up to [27:21] digit3; bit order gfedcba; 1 = segment lit.
REQ-006 load  input  1  one-cycle strobe; ssd is sampled on this cycle.
REQ-007 blank_mask  input  4  bit n = 1 forces digit n dark.
REQ-008 an  output  4  anode drive, active-low.
REQ-009 seg  output  7  segment drive, active-low, gfedcba.
REQ-010 busy  output  1  high while a loaded image awaits a frame boundary.
REQ-011 frame_done  output  1  one-cycle pulse on each digit3->digit0 wrap.

Function
REQ-012 The prescaler counts 0..SCAN_DIV-1 and wraps; at terminal count the digit index advances 0->1->2->3->0.
REQ-013 frame_done pulses in the same cycle the index wraps from 3 to 0.
REQ-014 load captures ssd into a holding register and sets busy on the next edge.
REQ-015 A load while busy overwrites the holding register (last wins); busy stays high.
REQ-016 At a frame boundary with busy high, holding is copied to the display register and busy clears; the new image first appears on digit0 of the next frame.
REQ-017 A load coinciding with a frame boundary: the old holding image commits, the new one is held, and busy stays high.
REQ-018 While prescaler < BLANK_CYC, an = 4'b1111.
REQ-019 Otherwise, an = ~(1 << index), unless blank_mask[index] = 1, in which case an = 4'b1111.
REQ-020 seg = ~display[index] when the digit is driven, else 7'b1111111.
REQ-021 an and seg are registered: they change one cycle after the index or prescaler value that selects them.
REQ-022 blank_mask is sampled every cycle and takes effect with one cycle of latency.
REQ-023 Only one anode is ever low in any cycle.

Reset
REQ-024 Reset clears prescaler, index, holding and display registers, busy and frame_done to 0.
REQ-025 Reset drives an = 4'b1111 and seg = 7'b1111111.
REQ-026 Reset asserted mid-frame discards any pending image; scanning restarts at digit0 with the prescaler at 0 after release.

Configuration
REQ-027 With SSD_DIM_EN defined, a 2-bit input brightness is added.
REQ-028 With SSD_DIM_EN, the anode is additionally forced off when prescaler >= BLANK_CYC + ((SCAN_DIV-BLANK_CYC)*(brightness+1))/4.
REQ-029 With SSD_DIM_EN, brightness = 3 gives behaviour identical to the macro being absent.
REQ-030 Without SSD_DIM_EN, the port does not exist and every driven slot stays on from BLANK_CYC to SCAN_DIV-1.

Structure
REQ-031 Shared package ssd_pkg holds NUM_DIGITS=4, SEG_W=7, the digit-index typedef (2 bits) and the all-off constants for an and seg.
REQ-032 The prescaler is a sub-module ssd_prescaler (parameter DIV; outputs count and tick); all else is in ssd_scan_driver.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-033 Reset then load ssd=28'h0000001 -> after the next frame_done: slot0 an=4'b1110 and seg=7'b1111110 for 6 cycles; other slots seg all 1s; busy cleared at that boundary.
REQ-034 Two loads 3 cycles apart within one frame (0x7F then 0x06 on digit0) -> only 0x06 is ever displayed; busy is high from the first load to the boundary.
REQ-035 blank_mask=4'b0100 -> an never equals 4'b1011; the other three digits scan normally; frame period is 32 cycles.
REQ-036 Reset pulsed while busy with an image pending -> after release an=4'b1111 and seg all 1s, busy=0, the pending image is never shown, and the first frame_done occurs 32 cycles later.
REQ-037 Load coinciding with a frame_done cycle -> previous image commits, busy remains 1, and the new image commits at the following boundary.
REQ-038 SSD_DIM_EN with brightness=0 -> each driven slot has its anode low for exactly 1 cycle (prescaler=2 only); brightness=3 -> low for 6 cycles.
